s38417_phase_bank: RTL and testbench
====================================

# s38417_phase_bank

Three-phase one-hot sequencer and 14-channel × 3-slot flag bank that drives the phase-select and triple-flag inputs of the s38417 comparator cone. It also registers the cone's single-bit result once per completed frame. Each accepted input word fills the slot of the current phase. A frame is three accepted words, one per phase, and ends with a frame pulse, result capture and match count.

## Interface
- NCH, 14, number of flag channels (triples)
- CNTW, 8, width of saturating match counter
- CK  input  1  clock, rising edge
- RST  input  1  asynchronous active-high reset
- start  input  1  IDLE→RUN request
- stop  input  1  request to stop at end of current frame
- clr  input  1  synchronous clear of bank, cap_q, match_cnt (state unaffected)
- din  input  NCH  one flag bit per channel for the current phase
- din_valid  input  1  din valid
- din_ready  output  1  block accepts din this cycle
- sel  output  3  one-hot phase select: sel[0], sel[1], sel[2]; 000 in IDLE
- bank  output  3*NCH  flags; bank[3*c+p] = channel c, phase p
- cap_in  input  1  combinational result from the downstream cone (computed from sel/bank)
- frame_done  output  1  one-cycle pulse after a frame completes
- cap_q  output  1  cap_in sampled on frame_done
- match_cnt  output  CNTW  count of frames with cap_in=1, saturating
- busy  output  1  state is RUN

## Operation
- States: IDLE, RUN. RST→IDLE.
- IDLE:
  - sel=000, din_ready=0.
  - start → RUN with sel=001 next cycle.
  - stop is ignored in IDLE.
- RUN:
  - din_ready=1; accept = din_valid & din_ready.
  - On accept with phase p: bank[3*c+p] ← din[c] for all c, and sel rotates left (001→010→100→001).
  - Slots of other phases hold their values.
  - No accept → sel and bank hold; there is no timeout.
  - start is ignored in RUN.
- Frame completion: an accept while sel=100 completes the frame.
  - frame_done=1 on the following cycle.
  - In that frame_done cycle: cap_q ← cap_in, and match_cnt ← match_cnt+1 if cap_in=1. The counter holds at 2^CNTW−1.
- stop:
  - stop sets a sticky stop_pend flag in RUN.
  - On a frame-completing accept with stop_pend (or with stop high that same cycle) → IDLE, sel=000, stop_pend cleared.
  - The bank is retained on stop.
  - frame_done still pulses for the final frame.
- clr:
  - clr has priority over a simultaneous accept's bank write; the sel rotation still occurs.
  - clr in a frame_done cycle → cap_q=0 and match_cnt=0 (clr wins).
- sel is one-hot in RUN at all times. Any non-one-hot value is a design error; the bench asserts on it.

## Timing
- Reset values: sel=000, bank=0, din_ready=0, frame_done=0, cap_q=0, match_cnt=0, busy=0, stop_pend=0.
- All outputs are registered except din_ready, which decodes from the state register. No output has a combinational path from din or din_valid.
- Latency:
  - start → sel=001 and din_ready=1: 1 cycle.
  - accept → bank/sel update visible: 1 cycle.
  - Third accept → frame_done: 1 cycle.
  - frame_done → cap_q/match_cnt visible: 1 cycle.
- Throughput: one accept per cycle; back-to-back frames have no bubble. The first accept of frame N+1 may occur in frame N's frame_done cycle.
- cap_in is sampled only in frame_done cycles. It must settle within the cycle, from the registered sel/bank.
- Asynchronous RST mid-frame: immediately returns to IDLE, clears all state, and drops any partial frame.

## Test plan
- Reset then start: after 1 cycle sel=001, busy=1, din_ready=1; bank=0, match_cnt=0.
- Single frame with din=14'h3FFF, 14'h0000, 14'h2AAA on consecutive cycles:
  - bank[3c]=1 for all c; bank[3c+1]=0; bank[3c+2]=1 for odd c only.
  - frame_done pulses on cycle 4; sel returns to 001.
- cap_in=1 during frame_done of 3 frames, then 0 for 1 frame → match_cnt=3, cap_q=0.
- CNTW=2 with 5 matching frames → match_cnt saturates at 3.
- Stop handling:
  - stop pulsed in phase 1: the frame finishes, frame_done pulses, then IDLE, sel=000, bank retained.
  - din_valid gaps of 2 cycles between accepts stretch the frame without corrupting slots.
- Reset and clear edge cases:
  - RST asserted asynchronously after 2 accepts → all outputs reset at once; after a new start, the first accept writes phase 0.
  - clr coincident with frame_done → cap_q=0, match_cnt=0.

Source files
------------

// File: rtl/s38417_phase_bank.sv
// Three-phase one-hot sequencer feeding a 14-channel x 3-slot flag bank, with
// per-frame capture of the downstream cone result and a saturating match counter.
module s38417_phase_bank #(
    parameter int NCH  = 14,
    parameter int CNTW = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    input  logic              stop,
    input  logic              clr,
    input  logic [NCH-1:0]    din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [2:0]        sel,
    output logic [3*NCH-1:0]  bank,
    input  logic              cap_in,
    output logic              frame_done,
    output logic              cap_q,
    output logic [CNTW-1:0]   match_cnt,
    output logic              busy
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t state;
    logic   stop_pend;
    logic   accept;
    logic   frame_end;

    assign din_ready = (state == RUN);
    assign busy      = (state == RUN);
    assign accept    = din_valid & din_ready;
    assign frame_end = accept & sel[2];

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            sel        <= 3'b000;
            stop_pend  <= 1'b0;
            bank       <= '0;
            frame_done <= 1'b0;
            cap_q      <= 1'b0;
            match_cnt  <= '0;
        end else begin
            frame_done <= frame_end;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        sel   <= 3'b001;
                    end
                end
                RUN: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    // A stop seen on the frame-closing accept itself still ends the run here.
                    if (accept) begin
                        if (sel[2]) begin
                            if (stop_pend || stop) begin
                                state     <= IDLE;
                                sel       <= 3'b000;
                                stop_pend <= 1'b0;
                            end else begin
                                sel <= 3'b001;
                            end
                        end else begin
                            sel <= {sel[1:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= 3'b000;
                end
            endcase

            if (clr) begin
                bank <= '0;
            end else if (accept) begin
                for (int c = 0; c < NCH; c++) begin
                    for (int p = 0; p < 3; p++) begin
                        if (sel[p]) begin
                            bank[3*c+p] <= din[c];
                        end
                    end
                end
            end

            // The cone result is only meaningful once the whole frame is in the bank.
            if (clr) begin
                cap_q     <= 1'b0;
                match_cnt <= '0;
            end else if (frame_done) begin
                cap_q <= cap_in;
                if (cap_in && (match_cnt != CNT_MAX)) begin
                    match_cnt <= match_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_s38417_phase_bank.sv
// Directed bench for s38417_phase_bank: phase sequencing, slot writes, frame
// capture, counter saturation (second instance with CNTW=2), stop, clr and reset.
module tb_s38417_phase_bank;

    logic        CK;
    logic        RST;
    logic        start;
    logic        stop;
    logic        clr;
    logic [13:0] din;
    logic        din_valid;
    logic        cap_in;

    logic        din_ready;
    logic [2:0]  sel;
    logic [41:0] bank;
    logic        frame_done;
    logic        cap_q;
    logic [7:0]  match_cnt;
    logic        busy;

    logic        din_ready2;
    logic [2:0]  sel2;
    logic [41:0] bank2;
    logic        frame_done2;
    logic        cap_q2;
    logic [1:0]  match_cnt2;
    logic        busy2;

    int checks = 0;
    int errors = 0;

    s38417_phase_bank #(.NCH(14), .CNTW(8)) dut (
        .CK(CK), .RST(RST), .start(start), .stop(stop), .clr(clr),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sel(sel), .bank(bank), .cap_in(cap_in), .frame_done(frame_done),
        .cap_q(cap_q), .match_cnt(match_cnt), .busy(busy)
    );

    s38417_phase_bank #(.NCH(14), .CNTW(2)) dut2 (
        .CK(CK), .RST(RST), .start(start), .stop(stop), .clr(clr),
        .din(din), .din_valid(din_valid), .din_ready(din_ready2),
        .sel(sel2), .bank(bank2), .cap_in(cap_in), .frame_done(frame_done2),
        .cap_q(cap_q2), .match_cnt(match_cnt2), .busy(busy2)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // While running, the phase select must always be exactly one-hot.
    always @(negedge CK) begin
        if (!RST && busy) begin
            checks++;
            assert ($onehot(sel)) else begin
                errors++;
                $error("[TB] FAIL sel_onehot observed=%b expected=one-hot", sel);
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge CK);
        #1;
    endtask

    task automatic apply_stimulus(input logic [13:0] d, input logic capv);
        din_valid = 1'b1;
        din       = d;
        cap_in    = capv;
        cyc();
        din_valid = 1'b0;
    endtask

    task automatic gap(input logic capv);
        din_valid = 1'b0;
        cap_in    = capv;
        cyc();
    endtask

    function automatic logic [41:0] build_bank(input logic [13:0] d0, input logic [13:0] d1,
                                               input logic [13:0] d2);
        logic [41:0] b;
        b = '0;
        for (int c = 0; c < 14; c++) begin
            b[3*c]   = d0[c];
            b[3*c+1] = d1[c];
            b[3*c+2] = d2[c];
        end
        return b;
    endfunction

    function automatic logic [41:0] frame1_bank();
        logic [41:0] b;
        b = '0;
        for (int c = 0; c < 14; c++) begin
            b[3*c]   = 1'b1;
            b[3*c+2] = (c % 2) == 1;
        end
        return b;
    endfunction

    initial begin
        RST = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0;
        din = '0; din_valid = 1'b0; cap_in = 1'b0;

        repeat (2) cyc();
        check_output("rst_sel", 64'(sel), 64'h0);
        check_output("rst_bank", 64'(bank), 64'h0);
        check_output("rst_ready", 64'(din_ready), 64'h0);
        check_output("rst_fd", 64'(frame_done), 64'h0);
        check_output("rst_capq", 64'(cap_q), 64'h0);
        check_output("rst_cnt", 64'(match_cnt), 64'h0);
        check_output("rst_busy", 64'(busy), 64'h0);
        RST = 1'b0;

        start = 1'b1; cyc(); start = 1'b0;
        check_output("start_sel", 64'(sel), 64'h1);
        check_output("start_busy", 64'(busy), 64'h1);
        check_output("start_ready", 64'(din_ready), 64'h1);
        check_output("start_bank", 64'(bank), 64'h0);
        check_output("start_cnt", 64'(match_cnt), 64'h0);

        // Frame 1
        apply_stimulus(14'h3FFF, 1'b0);
        check_output("f1_sel1", 64'(sel), 64'h2);
        check_output("f1_fd_early", 64'(frame_done), 64'h0);
        apply_stimulus(14'h0000, 1'b0);
        check_output("f1_sel2", 64'(sel), 64'h4);
        apply_stimulus(14'h2AAA, 1'b0);
        check_output("f1_fd", 64'(frame_done), 64'h1);
        check_output("f1_sel_wrap", 64'(sel), 64'h1);
        check_output("f1_bank", 64'(bank), 64'(frame1_bank()));

        // Frames 2-4 back-to-back; first accept shares the previous frame_done cycle
        apply_stimulus(14'h0155, 1'b1);
        check_output("f2_fd_low", 64'(frame_done), 64'h0);
        check_output("f2_capq", 64'(cap_q), 64'h1);
        check_output("f2_cnt", 64'(match_cnt), 64'h1);
        check_output("f2_sel", 64'(sel), 64'h2);
        apply_stimulus(14'h0000, 1'b0);
        apply_stimulus(14'h0000, 1'b0);
        check_output("f2_fd", 64'(frame_done), 64'h1);
        apply_stimulus(14'h0000, 1'b1);
        apply_stimulus(14'h0000, 1'b0);
        apply_stimulus(14'h0000, 1'b0);
        apply_stimulus(14'h0000, 1'b1);
        check_output("f4_cnt_after3", 64'(match_cnt), 64'h3);
        apply_stimulus(14'h0000, 1'b0);
        apply_stimulus(14'h0000, 1'b0);
        gap(1'b0);
        check_output("f4_capq0", 64'(cap_q), 64'h0);
        check_output("f4_cnt", 64'(match_cnt), 64'h3);
        check_output("f4_cnt2", 64'(match_cnt2), 64'h3);

        // Frames 5-6 matching: 5 matches total, narrow counter saturates
        apply_stimulus(14'h0000, 1'b0);
        apply_stimulus(14'h0000, 1'b0);
        apply_stimulus(14'h0000, 1'b0);
        apply_stimulus(14'h0001, 1'b1);
        apply_stimulus(14'h0002, 1'b0);
        apply_stimulus(14'h0004, 1'b0);
        gap(1'b1);
        check_output("f6_cnt", 64'(match_cnt), 64'h5);
        check_output("f6_cnt2_sat", 64'(match_cnt2), 64'h3);
        check_output("f6_capq", 64'(cap_q), 64'h1);
        check_output("f6_bank", 64'(bank), 64'(build_bank(14'h0001, 14'h0002, 14'h0004)));

        // Frame 7: stop pulsed in phase 1, with gaps between accepts
        apply_stimulus(14'h1234, 1'b0);
        check_output("f7_sel1", 64'(sel), 64'h2);
        stop = 1'b1; gap(1'b0); stop = 1'b0;
        check_output("f7_stop_sel", 64'(sel), 64'h2);
        check_output("f7_stop_busy", 64'(busy), 64'h1);
        apply_stimulus(14'h0F0F, 1'b0);
        gap(1'b0);
        gap(1'b0);
        check_output("f7_gap_sel", 64'(sel), 64'h4);
        check_output("f7_gap_bank", 64'(bank), 64'(build_bank(14'h1234, 14'h0F0F, 14'h0004)));
        check_output("f7_gap_fd", 64'(frame_done), 64'h0);
        apply_stimulus(14'h3C3C, 1'b0);
        check_output("f7_fd", 64'(frame_done), 64'h1);
        check_output("f7_sel_idle", 64'(sel), 64'h0);
        check_output("f7_busy", 64'(busy), 64'h0);
        check_output("f7_ready", 64'(din_ready), 64'h0);
        gap(1'b0);
        check_output("f7_fd_low", 64'(frame_done), 64'h0);
        check_output("f7_capq", 64'(cap_q), 64'h0);
        check_output("f7_cnt", 64'(match_cnt), 64'h5);
        check_output("f7_bank_kept", 64'(bank), 64'(build_bank(14'h1234, 14'h0F0F, 14'h3C3C)));

        // stop in IDLE is ignored and must not linger into the next run
        stop = 1'b1; gap(1'b0); stop = 1'b0;
        check_output("idle_stop_busy", 64'(busy), 64'h0);
        start = 1'b1; gap(1'b0); start = 1'b0;
        check_output("restart_sel", 64'(sel), 64'h1);
        apply_stimulus(14'h3FFF, 1'b0);
        apply_stimulus(14'h3FFF, 1'b0);
        apply_stimulus(14'h3FFF, 1'b0);
        check_output("f8_fd", 64'(frame_done), 64'h1);
        check_output("f8_sel", 64'(sel), 64'h1);
        check_output("f8_busy", 64'(busy), 64'h1);

        // clr coincident with frame_done
        clr = 1'b1; gap(1'b1); clr = 1'b0;
        check_output("clr_capq", 64'(cap_q), 64'h0);
        check_output("clr_cnt", 64'(match_cnt), 64'h0);
        check_output("clr_cnt2", 64'(match_cnt2), 64'h0);
        check_output("clr_bank", 64'(bank), 64'h0);

        // clr beats the bank write but sel still rotates
        clr = 1'b1; apply_stimulus(14'h3FFF, 1'b0); clr = 1'b0;
        check_output("clr_acc_sel", 64'(sel), 64'h2);
        check_output("clr_acc_bank", 64'(bank), 64'h0);
        apply_stimulus(14'h3FFF, 1'b0);
        check_output("acc_ph1_bank", 64'(bank), 64'(build_bank(14'h0000, 14'h3FFF, 14'h0000)));
        check_output("acc_ph1_sel", 64'(sel), 64'h4);

        // Asynchronous reset mid-frame after two accepts
        #2 RST = 1'b1;
        #1;
        check_output("arst_sel", 64'(sel), 64'h0);
        check_output("arst_busy", 64'(busy), 64'h0);
        check_output("arst_ready", 64'(din_ready), 64'h0);
        check_output("arst_bank", 64'(bank), 64'h0);
        #1 RST = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        apply_stimulus(14'h1555, 1'b0);
        check_output("arst_ph0_bank", 64'(bank), 64'(build_bank(14'h1555, 14'h0000, 14'h0000)));
        check_output("arst_ph0_sel", 64'(sel), 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
